// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: segmented-carry N-bit add/sub with valid/ready handshake and C/V/Z flags
module pipelined_adder_sub #(
    parameter int N      = 64,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V,
    output logic         Z
);
    localparam int SEG = N / STAGES;
    assign in_ready = !(out_valid && !out_ready);
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = N - k * SEG;
        logic                   vi, ci;
        logic [RW-1:0]          ai, bi;
        logic [(k+1)*SEG-1:0]   rn;
        logic [SEG:0]           sum;
        assign sum = {1'b0, ai[SEG-1:0]} + {1'b0, bi[SEG-1:0]} + {{SEG{1'b0}}, ci};
        if (k == 0) begin : g_src
            assign vi = in_valid;
            assign ai = A;
            assign bi = sub ? ~B : B;
            assign ci = sub ? ~Cin : Cin;
            assign rn = sum[SEG-1:0];
        end else begin : g_src
            assign vi = g_stage[k-1].g_mid.v_q;
            assign ai = g_stage[k-1].g_mid.a_q;
            assign bi = g_stage[k-1].g_mid.b_q;
            assign ci = g_stage[k-1].g_mid.c_q;
            assign rn = {sum[SEG-1:0], g_stage[k-1].g_mid.r_q};
        end
        if (k < STAGES - 1) begin : g_mid
            logic                 v_q, c_q;
            logic [RW-SEG-1:0]    a_q, b_q;
            logic [(k+1)*SEG-1:0] r_q;
            always_ff @(posedge clk)
                if (rst)
                    v_q <= 1'b0;
                else if (in_ready) begin
                    v_q <= vi;
                    c_q <= sum[SEG];
                    a_q <= ai[RW-1:SEG];
                    b_q <= bi[RW-1:SEG];
                    r_q <= rn;
                end
        end else begin : g_last
            always_ff @(posedge clk)
                if (rst) begin
                    out_valid <= 1'b0;
                    S         <= '0;
                    Cout      <= 1'b0;
                    V         <= 1'b0;
                    Z         <= 1'b0;
                end else if (in_ready) begin
                    out_valid <= vi;
                    if (vi) begin
                        S    <= rn;
                        Cout <= sum[SEG];
                        V    <= ai[SEG-1] ^ bi[SEG-1] ^ sum[SEG-1] ^ sum[SEG];
                        Z    <= rn == '0;
                    end
                end
        end
    end
endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb_pipelined_adder_sub: directed vectors, backpressure, random scoreboard and mid-flight reset
module tb_pipelined_adder_sub;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, V, Z;
    logic [63:0] A, B, S;
    int          checks = 0, failures = 0, ret = 0, stall_cnt = 0, lat;
    bit          mon_en = 0, held = 0, done = 0;
    logic [63:0] h_s;
    logic        h_c, h_v, h_z;
    logic [66:0] exp_q[$];
    logic [66:0] e;

    typedef struct {
        logic [63:0] a, b;
        logic        cin, sb;
        logic [63:0] s;
        logic        c, v, z;
    } vec_t;
    vec_t vt[10];

    pipelined_adder_sub #(.N(64), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .V(V), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sb);
        logic [63:0] be;
        logic        ce, ov;
        logic [64:0] t;
        be = sb ? ~b : b;
        ce = sb ? ~cin : cin;
        t  = {1'b0, a} + {1'b0, be} + {64'd0, ce};
        ov = (a[63] == be[63]) && (t[63] != a[63]);
        return {t[64], ov, t[63:0] == 64'd0, t[63:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 0;
        end else if (mon_en) begin
            if (held) begin
                chk("hold_S", S, h_s);
                chk("hold_Cout", {63'd0, Cout}, {63'd0, h_c});
                chk("hold_V", {63'd0, V}, {63'd0, h_v});
                chk("hold_Z", {63'd0, Z}, {63'd0, h_z});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("spurious_out", {63'd0, out_valid}, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_S", S, e[63:0]);
                    chk("sb_Cout", {63'd0, Cout}, {63'd0, e[66]});
                    chk("sb_V", {63'd0, V}, {63'd0, e[65]});
                    chk("sb_Z", {63'd0, Z}, {63'd0, e[64]});
                    ret++;
                end
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
                held = 1;
                h_s = S; h_c = Cout; h_v = V; h_z = Z;
            end else
                held = 0;
            if (in_valid && in_ready)
                exp_q.push_back(model(A, B, Cin, sub));
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sb);
        int t;
        A = a; B = b; Cin = cin; sub = sb; in_valid = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 200) chk("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd();
        case ($urandom_range(7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        vt[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
        vt[1] = '{'1, '1, 1'b1, 1'b0, '1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1};
        vt[3] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[5] = '{64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vt[6] = '{64'd5, 64'd5, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
        vt[7] = '{64'd3, 64'd1, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0};
        vt[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vt[9] = '{64'd0, 64'd0, 1'b1, 1'b1, '1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b1; A = 64'h1234_5678_9ABC_DEF0; B = 64'h1111; Cin = 1'b1; sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_S", S, 64'd0);
        chk("rst_Cout", {63'd0, Cout}, 64'd0);
        chk("rst_V", {63'd0, V}, 64'd0);
        chk("rst_Z", {63'd0, Z}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0; in_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            A = vt[i].a; B = vt[i].b; Cin = vt[i].cin; sub = vt[i].sb; in_valid = 1'b1;
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_S", i), S, vt[i].s);
            chk($sformatf("vec%0d_Cout", i), {63'd0, Cout}, {63'd0, vt[i].c});
            chk($sformatf("vec%0d_V", i), {63'd0, V}, {63'd0, vt[i].v});
            chk($sformatf("vec%0d_Z", i), {63'd0, Z}, {63'd0, vt[i].z});
        end
        @(posedge clk); #1;

        mon_en = 1; stall_cnt = 0; ret = 0;
        fork
            for (int i = 0; i < 10; i++) send(64'd100 * i + 64'hFFFF, 64'(i), i[0], i[1]);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_results", 64'(ret), 64'd10);
        chk("bp_stall_cycles", 64'(stall_cnt), 64'd3);

        ret = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(rnd(), rnd(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk); #1;
                out_ready = $urandom_range(3) != 0;
            end
        join
        out_ready = 1'b1;
        drain();
        chk("rand_results", 64'(ret), 64'd1000);

        ret = 0;
        for (int i = 0; i < 3; i++) send(64'hABCD + 64'(i), 64'd3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        lat = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        chk("midrst_ghosts", 64'(lat), 64'd0);
        chk("midrst_retired", 64'(ret), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
